// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: arbitrates WB against a buffered long-latency
// result FIFO and tracks per-register pending long-latency writes for decode.
module rf_write_sched #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             wb_stall,
  input  logic             ml_issue,
  input  logic [4:0]       ml_issue_rd,
  output logic             issue_busy,
  input  logic             ml_valid,
  input  logic [4:0]       ml_rd,
  input  logic [31:0]      ml_data,
  output logic             ml_ready,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  output logic             busy_rs,
  output logic             busy_rt,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] fifo_count
);

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       starve;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  logic             rf_src_fifo;

  logic wb_valid;
  logic fifo_empty;
  logic starved;
  logic wb_win;
  logic fifo_win;
  logic push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A write to r0 is swallowed: it never stalls and never wins the port.
  assign wb_valid   = wb_we && (wb_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign starved    = (starve == 4'(STARVE_LIMIT));
  assign wb_win     = wb_valid && (!starved || fifo_empty);
  assign fifo_win   = !fifo_empty && !wb_win;
  assign wb_stall   = wb_valid && !wb_win;

  // ml_ready looks only at the current count; a same-cycle pop gives no credit.
  assign ml_ready   = (count < CNT_W'(DEPTH));
  assign push       = ml_valid && ml_ready && (ml_rd != 5'd0);
  assign fifo_count = count;

  // pending[0] is held at 0, so the r0 lookups need no special case.
  assign issue_busy = pending[ml_issue_rd];
  assign busy_rs    = pending[rs];
  assign busy_rt    = pending[rt];

  always_comb begin
    // NOTE: default assignment first so no path leaves pending_nxt unassigned (no latch).
    pending_nxt = pending;
    if (rf_we && rf_src_fifo) pending_nxt[rf_rd] = 1'b0;
    if (ml_issue && (ml_issue_rd != 5'd0)) pending_nxt[ml_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= ml_rd;
      mem_data[wr_ptr] <= ml_data;
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve      <= '0;
      pending     <= '0;
      rf_we       <= 1'b0;
      rf_rd       <= 5'd0;
      rf_wdata    <= 32'd0;
      rf_src_fifo <= 1'b0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_win) rd_ptr <= ptr_inc(rd_ptr);

      if (push && !fifo_win)      count <= count + 1'b1;
      else if (!push && fifo_win) count <= count - 1'b1;

      if (fifo_win)                                starve <= '0;
      else if (wb_win && !fifo_empty && !starved) starve <= starve + 1'b1;

      rf_we       <= wb_win || fifo_win;
      rf_src_fifo <= fifo_win;
      if (fifo_win) begin
        rf_rd    <= mem_rd[rd_ptr];
        rf_wdata <= mem_data[rd_ptr];
      end else if (wb_win) begin
        rf_rd    <= wb_rd;
        rf_wdata <= wb_data;
      end

      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: scoreboard of expected register-file writes
// plus per-scenario inline checks of stall, ready, occupancy and busy outputs.
module tb_rf_write_sched;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             wb_stall;
  logic             ml_issue;
  logic [4:0]       ml_issue_rd;
  logic             issue_busy;
  logic             ml_valid;
  logic [4:0]       ml_rd;
  logic [31:0]      ml_data;
  logic             ml_ready;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             busy_rs;
  logic             busy_rt;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic [CNT_W-1:0] fifo_count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks = 0;
  int  errors = 0;

  rf_write_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .ml_issue(ml_issue), .ml_issue_rd(ml_issue_rd), .issue_busy(issue_busy),
    .ml_valid(ml_valid), .ml_rd(ml_rd), .ml_data(ml_data), .ml_ready(ml_ready),
    .rs(rs), .rt(rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every register-file write is matched against the next expected write in order.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected got rd=%0d data=%h, none expected", rf_rd, rf_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rf_rd, rf_wdata} !== exp_e) begin
          errors++;
          $display("FAIL rf_write_order got rd=%0d data=%h exp rd=%0d data=%h",
                   rf_rd, rf_wdata, exp_e.rd, exp_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ml_issue = 1'b0; ml_issue_rd = 5'd0;
    ml_valid = 1'b0; ml_rd = 5'd0; ml_data = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] seen;
    ml_issue = 1'b1; ml_issue_rd = 5'd4;
    cyc();
    ml_issue_rd = 5'd11;
    cyc();
    ml_issue = 1'b0; rs = 5'd4; rt = 5'd11; #1;
    checks++;
    if ({busy_rs, busy_rt} !== 2'b11) begin
      errors++; $display("FAIL reset_pre_busy got %b exp 11", {busy_rs, busy_rt});
    end
    rst_n = 1'b0;
    ml_valid = 1'b1; ml_rd = 5'd4; ml_data = 32'hAAAA_0004;
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'hAAAA_0006;
    cyc();
    rst_n = 1'b1; idle(); #1;
    checks++;
    if ({rf_we, fifo_count, ml_ready} !== {1'b0, CNT_W'(0), 1'b1}) begin
      errors++;
      $display("FAIL reset_state got rf_we=%b count=%0d ready=%b exp 0 0 1", rf_we, fifo_count, ml_ready);
    end
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i); #1;
      seen[i] = busy_rs | busy_rt;
    end
    checks++;
    if (seen !== 32'd0) begin
      errors++; $display("FAIL reset_busy got %h exp 00000000", seen);
    end
    cyc();
    checks++;
    if (fifo_count !== CNT_W'(0)) begin
      errors++; $display("FAIL reset_push_dropped got %0d exp 0", fifo_count);
    end
  endtask

  task automatic test_wb_only();
    logic [4:0]  rd;
    logic [31:0] d;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    exp_q.push_back(wr_t'{5'd5, 32'h0000_1234});
    #1;
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++; $display("FAIL wb_stall_idle got %b exp 0", wb_stall);
    end
    cyc();
    idle();
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      errors++;
      $display("FAIL wb_write got we=%b rd=%0d data=%h exp 1 5 00001234", rf_we, rf_rd, rf_wdata);
    end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF; #1;
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++; $display("FAIL wb_r0_stall got %b exp 0", wb_stall);
    end
    cyc();
    idle();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL wb_r0_write got rf_we=%b exp 0", rf_we);
    end
    for (int k = 0; k < 4; k++) begin
      rd = 5'(k * 7 + 3);
      d  = $urandom;
      wb_we = 1'b1; wb_rd = rd; wb_data = d;
      exp_q.push_back(wr_t'{rd, d});
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_scoreboard();
    ml_issue = 1'b1; ml_issue_rd = 5'd7; #1;
    checks++;
    if (issue_busy !== 1'b0) begin
      errors++; $display("FAIL issue_busy_free got %b exp 0", issue_busy);
    end
    cyc();
    ml_issue = 1'b0; rs = 5'd7; rt = 5'd0; #1;
    checks++;
    if ({busy_rs, busy_rt, issue_busy} !== 3'b101) begin
      errors++; $display("FAIL sb_pending got rs/rt/issue=%b exp 101", {busy_rs, busy_rt, issue_busy});
    end
    ml_valid = 1'b1; ml_rd = 5'd7; ml_data = 32'h0000_BEEF;
    exp_q.push_back(wr_t'{5'd7, 32'h0000_BEEF});
    cyc();
    ml_valid = 1'b0; #1;
    checks++;
    if ({fifo_count, rf_we, busy_rs} !== {CNT_W'(1), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sb_head got count=%0d we=%b busy=%b exp 1 0 1", fifo_count, rf_we, busy_rs);
    end
    cyc();
    checks++;
    if ({rf_we, rf_rd, rf_wdata, busy_rs} !== {1'b1, 5'd7, 32'h0000_BEEF, 1'b1}) begin
      errors++;
      $display("FAIL sb_commit got we=%b rd=%0d data=%h busy=%b exp 1 7 0000beef 1",
               rf_we, rf_rd, rf_wdata, busy_rs);
    end
    cyc();
    checks++;
    if ({busy_rs, issue_busy} !== 2'b00) begin
      errors++; $display("FAIL sb_cleared got busy/issue=%b exp 00", {busy_rs, issue_busy});
    end

    // Re-issue to r12 on the very edge its earlier result commits: the set must win.
    ml_issue = 1'b1; ml_issue_rd = 5'd12;
    cyc();
    ml_issue = 1'b0;
    ml_valid = 1'b1; ml_rd = 5'd12; ml_data = 32'h0000_C0DE;
    exp_q.push_back(wr_t'{5'd12, 32'h0000_C0DE});
    cyc();
    ml_valid = 1'b0;
    cyc();
    ml_issue = 1'b1; ml_issue_rd = 5'd12;
    cyc();
    ml_issue = 1'b0; rs = 5'd12; #1;
    checks++;
    if (busy_rs !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins got %b exp 1", busy_rs);
    end
    ml_valid = 1'b1; ml_rd = 5'd12; ml_data = 32'h0000_0F0F;
    exp_q.push_back(wr_t'{5'd12, 32'h0000_0F0F});
    cyc();
    ml_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (busy_rs !== 1'b0) begin
      errors++; $display("FAIL sb_set_wins_clear got %b exp 0", busy_rs);
    end

    ml_valid = 1'b1; ml_rd = 5'd0; ml_data = 32'h1111_0000; #1;
    checks++;
    if (ml_ready !== 1'b1) begin
      errors++; $display("FAIL ml_r0_ready got %b exp 1", ml_ready);
    end
    cyc();
    ml_valid = 1'b0; #1;
    checks++;
    if (fifo_count !== CNT_W'(0)) begin
      errors++; $display("FAIL ml_r0_dropped got %0d exp 0", fifo_count);
    end
    cyc();
  endtask

  task automatic test_starvation();
    logic hold;
    logic exp_stall;
    ml_valid = 1'b1; ml_rd = 5'd3; ml_data = 32'hA5A5_0003;
    cyc();
    ml_valid = 1'b0;
    hold = 1'b0;
    for (int k = 1; k <= STARVE_LIMIT + 2; k++) begin
      if (!hold) begin
        wb_rd = 5'd20; wb_data = 32'h5000_0000 + 32'(k);
      end
      wb_we = 1'b1; #1;
      exp_stall = (k == STARVE_LIMIT + 1);
      checks++;
      if (wb_stall !== exp_stall) begin
        errors++; $display("FAIL starve_stall_%0d got %b exp %b", k, wb_stall, exp_stall);
      end
      if (exp_stall) exp_q.push_back(wr_t'{5'd3, 32'hA5A5_0003});
      else           exp_q.push_back(wr_t'{5'd20, wb_data});
      hold = exp_stall;
      cyc();
    end
    idle(); #1;
    checks++;
    if (fifo_count !== CNT_W'(0)) begin
      errors++; $display("FAIL starve_drained got %0d exp 0", fifo_count);
    end
    cyc();
  endtask

  task automatic test_full_simultaneous();
    wb_we = 1'b1; wb_rd = 5'd21; wb_data = 32'hF000_0001;
    ml_valid = 1'b1; ml_rd = 5'd22; ml_data = 32'hE000_0001;
    exp_q.push_back(wr_t'{5'd21, 32'hF000_0001});
    cyc();
    wb_data = 32'hF000_0002;
    ml_rd = 5'd23; ml_data = 32'hE000_0002; #1;
    checks++;
    if (ml_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_one got %b exp 1", ml_ready);
    end
    exp_q.push_back(wr_t'{5'd21, 32'hF000_0002});
    cyc();
    wb_data = 32'hF000_0003; ml_valid = 1'b0; #1;
    checks++;
    if ({ml_ready, fifo_count, wb_stall} !== {1'b0, CNT_W'(2), 1'b0}) begin
      errors++;
      $display("FAIL full_state got ready=%b count=%0d stall=%b exp 0 2 0", ml_ready, fifo_count, wb_stall);
    end
    exp_q.push_back(wr_t'{5'd21, 32'hF000_0003});
    cyc();
    idle(); #1;
    checks++;
    if (ml_ready !== 1'b0) begin
      errors++; $display("FAIL full_no_credit got %b exp 0", ml_ready);
    end
    exp_q.push_back(wr_t'{5'd22, 32'hE000_0001});
    cyc();
    checks++;
    if ({fifo_count, ml_ready} !== {CNT_W'(1), 1'b1}) begin
      errors++; $display("FAIL full_after_pop got count=%0d ready=%b exp 1 1", fifo_count, ml_ready);
    end
    ml_valid = 1'b1; ml_rd = 5'd24; ml_data = 32'hE000_0003;
    exp_q.push_back(wr_t'{5'd23, 32'hE000_0002});
    cyc();
    ml_valid = 1'b0; #1;
    checks++;
    if (fifo_count !== CNT_W'(1)) begin
      errors++; $display("FAIL push_pop_count got %0d exp 1", fifo_count);
    end
    exp_q.push_back(wr_t'{5'd24, 32'hE000_0003});
    cyc();
    checks++;
    if (fifo_count !== CNT_W'(0)) begin
      errors++; $display("FAIL push_pop_drained got %0d exp 0", fifo_count);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    ml_issue = 1'b1; ml_issue_rd = 5'd3;
    wb_we = 1'b1; wb_rd = 5'd25; wb_data = 32'hC000_0001;
    exp_q.push_back(wr_t'{5'd25, 32'hC000_0001});
    cyc();
    ml_issue_rd = 5'd9; wb_data = 32'hC000_0002;
    ml_valid = 1'b1; ml_rd = 5'd3; ml_data = 32'hD000_0003;
    exp_q.push_back(wr_t'{5'd25, 32'hC000_0002});
    cyc();
    ml_issue = 1'b0; wb_data = 32'hC000_0003;
    ml_rd = 5'd9; ml_data = 32'hD000_0009;
    exp_q.push_back(wr_t'{5'd25, 32'hC000_0003});
    cyc();
    idle(); rs = 5'd3; rt = 5'd9; #1;
    checks++;
    if ({busy_rs, busy_rt, fifo_count} !== {2'b11, CNT_W'(2)}) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b count=%0d exp 11 2", {busy_rs, busy_rt}, fifo_count);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; #1;
    checks++;
    if ({rf_we, fifo_count, busy_rs, busy_rt} !== {1'b0, CNT_W'(0), 2'b00}) begin
      errors++;
      $display("FAIL midrst_state got we=%b count=%0d busy=%b exp 0 0 00",
               rf_we, fifo_count, {busy_rs, busy_rt});
    end
    repeat (4) cyc();
    checks++;
    if ({fifo_count, busy_rs, busy_rt} !== {CNT_W'(0), 2'b00}) begin
      errors++;
      $display("FAIL midrst_after got count=%0d busy=%b exp 0 00", fifo_count, {busy_rs, busy_rt});
    end
  endtask

  initial begin
    rst_n = 1'b0; rs = 5'd0; rt = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_wb_only();
    test_scoreboard();
    test_starvation();
    test_full_simultaneous();
    test_reset_mid();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL writes_missing got %0d outstanding exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler and scoreboard for the 32x32 register file. It shares the file's single write port between the pipeline writeback stage and a long-latency unit (multiply/divide). Long-latency results are buffered in a small FIFO, and a per-register pending scoreboard tells decode when a source register is still waiting on such a result. It sits between WB, the long-latency unit and the register file's write inputs.

## Interface
- DEPTH, 2: long-latency result FIFO entries, 2..8.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose to WB before it forces a win, 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_we  in  1  writeback request.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback data.
- wb_stall  out  1  combinational; WB request not taken this cycle, hold wb_* stable.
- ml_issue  in  1  long-latency op issued; reserves ml_issue_rd.
- ml_issue_rd  in  5  destination reserved at issue.
- issue_busy  out  1  combinational, pending[ml_issue_rd]; issue must not be asserted while high.
- ml_valid  in  1  long-latency result valid.
- ml_rd  in  5  result destination.
- ml_data  in  32  result data.
- ml_ready  out  1  FIFO can accept (count < DEPTH).
- rs, rt  in  5 each  decode source registers.
- busy_rs, busy_rt  out  1 each  combinational, pending[rs] / pending[rt]; register 0 always 0.
- rf_we  out  1  registered write enable to register file.
- rf_rd  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Reset (rst_n low at a rising edge): FIFO emptied, contents discarded; pending = 0; starve counter = 0; rf_we = 0, rf_rd = 0, rf_wdata = 0; fifo_count = 0. Reset mid-operation drops buffered results and reservations without writing them.
- WB request is valid when wb_we = 1 and wb_rd != 0. A wb_rd = 0 request is consumed silently, never stalled, and never reaches rf_we.
- FIFO push when ml_valid && ml_ready. A result with ml_rd = 0 is accepted and discarded, not stored.
- Arbitration per cycle:
  - WB request valid and starve counter < STARVE_LIMIT: WB wins.
  - FIFO non-empty and starve counter == STARVE_LIMIT: FIFO head wins; wb_stall = 1.
  - No WB request: FIFO head wins if non-empty.
  - No request from either side: rf_we = 0 next cycle.
- Starve counter:
  - Increments when FIFO is non-empty and WB wins.
  - Clears on every FIFO pop.
  - Saturates at STARVE_LIMIT.
- Winner is registered into rf_we/rf_rd/rf_wdata. A tag bit rf_src_fifo is kept internally.
- Scoreboard, 32 pending bits:
  - ml_issue with ml_issue_rd != 0 sets pending[ml_issue_rd].
  - A bit clears at the edge where registered rf_we = 1 with rf_src_fifo = 1, i.e. the edge the register file commits.
  - If set and clear target the same register in one cycle, set wins.
  - WB writes never clear bits. pending[0] is constant 0.
- Push and pop in the same cycle: allowed, count unchanged. ml_ready uses the current count only; there is no credit from a same-cycle pop.

## Timing
- WB request at cycle N (won) -> rf_we = 1 during N+1 -> register file updated at end of N+1.
- ml result accepted at edge ending cycle N -> head visible cycle N+1 -> rf_we earliest N+2 -> pending cleared and busy low from N+3.
- wb_stall, issue_busy, busy_rs/rt, ml_ready: combinational, same cycle.
- Under continuous WB traffic a FIFO entry waits at most STARVE_LIMIT+1 cycles as head.
- FIFO full: ml_ready = 0 until the cycle after a pop.
- FIFO empty: no pop; the counter stays 0.

## Test plan
- Reset: drive traffic, then hold rst_n low 1 cycle -> rf_we = 0, fifo_count = 0, busy_rs = 0 for all rs, ml_ready = 1.
- WB only: wb_we = 1, wb_rd = 5, wb_data = 0x1234 at cycle N -> rf_we = 1, rf_rd = 5, rf_wdata = 0x1234 in N+1. wb_rd = 0 -> rf_we stays 0.
- Scoreboard: ml_issue rd = 7 -> busy_rs = 1 for rs = 7 next cycle. Push result rd = 7, data = 0xBEEF with WB idle -> rf_we with rd 7 two cycles later; busy_rs = 0 the cycle after that. issue_busy = 1 for ml_issue_rd = 7 while pending.
- Starvation: FIFO holds one entry, WB valid every cycle, STARVE_LIMIT = 4 -> WB wins 4 cycles, then wb_stall = 1 and the FIFO entry writes. The held WB request writes the following cycle with unchanged data.
- Full/simultaneous: DEPTH = 2, push 2 with WB busy -> ml_ready = 0. Pop and push in the same cycle with count 1 -> count stays 1 and data order is preserved.
- Reset mid-operation: 2 entries buffered, pending[3] and pending[9] set, rst_n low -> no rf_we for those entries; pending = 0.
